// File: rtl/clause_evaluator_k.sv
// K-literal clause evaluator with replicated truth tables and a valid/ready pipeline.
// Optional break detection (probe_addr/break_hit) is enabled by defining CLAUSE_EVAL_BREAK_EN.

module clause_lit_lane #(
  parameter int VAR_AW = 11
) (
  input  logic              clk,
  input  logic              flip_valid,
  input  logic [VAR_AW-1:0] flip_addr,
  input  logic              flip_value,
  input  logic [VAR_AW-1:0] rd_addr,
  output logic              rd_val
);
  logic mem [0:(1<<VAR_AW)-1];

  always_ff @(posedge clk)
    if (flip_valid) mem[flip_addr] <= flip_value;

  // Write-first bypass: a flip on the accepting edge is visible to that clause.
  assign rd_val = (flip_valid && flip_addr == rd_addr) ? flip_value : mem[rd_addr];
endmodule

module clause_evaluator_k #(
  parameter int K      = 3,
  parameter int VAR_AW = 11,
  parameter int CNT_W  = $clog2(K+1),
  parameter int IDX_W  = $clog2(K)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [K*VAR_AW-1:0]   lit_addr,
  input  logic [K-1:0]          lit_neg,
  input  logic                  flip_valid,
  input  logic [VAR_AW-1:0]     flip_addr,
  input  logic                  flip_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sat,
  output logic [CNT_W-1:0]      true_cnt,
  output logic [IDX_W-1:0]      crit_idx,
  output logic [K-1:0]          lit_val
`ifdef CLAUSE_EVAL_BREAK_EN
  ,
  input  logic [VAR_AW-1:0]     probe_addr,
  output logic                  break_hit
`endif
);
  // Stage 0 holds the table snapshot taken at accept, stage 1 the literal values, stage 2 the outputs.
  logic [2:0]       vld_pipe;
  logic             rdy_q;
  logic             adv0, adv1, adv2, fire;
  logic [K-1:0]     rd_val, val0, neg0, lit1;
  logic [CNT_W-1:0] cnt_nxt;
  logic [IDX_W-1:0] idx_nxt;

  assign adv2      = !vld_pipe[2] || out_ready;
  assign adv1      = !vld_pipe[1] || adv2;
  assign adv0      = !vld_pipe[0] || adv1;
  assign in_ready  = rdy_q && adv0;
  assign fire      = in_valid && in_ready;
  assign out_valid = vld_pipe[2];

  for (genvar i = 0; i < K; i++) begin : g_lane
    clause_lit_lane #(.VAR_AW(VAR_AW)) u_lane (
      .clk        (clk),
      .flip_valid (flip_valid),
      .flip_addr  (flip_addr),
      .flip_value (flip_value),
      .rd_addr    (lit_addr[i*VAR_AW +: VAR_AW]),
      .rd_val     (rd_val[i])
    );
  end

  always_comb begin
    cnt_nxt = '0;
    idx_nxt = '0;
    for (int i = K-1; i >= 0; i--) begin
      cnt_nxt = cnt_nxt + CNT_W'(lit1[i]);
      if (lit1[i]) idx_nxt = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      rdy_q    <= 1'b0;
      val0     <= '0;
      neg0     <= '0;
      lit1     <= '0;
      sat      <= 1'b0;
      true_cnt <= '0;
      crit_idx <= '0;
      lit_val  <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (adv0) begin
        vld_pipe[0] <= fire;
        if (fire) begin
          val0 <= rd_val;
          neg0 <= lit_neg;
        end
      end
      if (adv1) begin
        vld_pipe[1] <= vld_pipe[0];
        if (vld_pipe[0]) lit1 <= val0 ^ neg0;
      end
      if (adv2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          lit_val  <= lit1;
          true_cnt <= cnt_nxt;
          crit_idx <= idx_nxt;
          sat      <= |lit1;
        end
      end
    end
  end

`ifdef CLAUSE_EVAL_BREAK_EN
  logic [K*VAR_AW-1:0] addr0, addr1;
  logic [VAR_AW-1:0]   probe0, probe1;
  logic                brk_nxt;

  assign brk_nxt = (cnt_nxt == CNT_W'(1)) && (addr1[idx_nxt*VAR_AW +: VAR_AW] == probe1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr0     <= '0;
      addr1     <= '0;
      probe0    <= '0;
      probe1    <= '0;
      break_hit <= 1'b0;
    end else begin
      if (adv0 && fire) begin
        addr0  <= lit_addr;
        probe0 <= probe_addr;
      end
      if (adv1 && vld_pipe[0]) begin
        addr1  <= addr0;
        probe1 <= probe0;
      end
      if (adv2 && vld_pipe[1]) break_hit <= brk_nxt;
    end
  end
`endif
endmodule

// File: tb/tb_clause_evaluator_k.sv
// Bench for clause_evaluator_k (K=3): vector table, scoreboard queue, stall/reset/flip sequences.
module tb_clause_evaluator_k;
  localparam int K = 3, AW = 11;

  typedef struct packed {
    logic [2:0] lv;
    logic [1:0] cnt;
    logic [1:0] idx;
    logic       sat;
    logic       brk;
  } exp_t;

  typedef struct packed {
    logic [K*AW-1:0] addr;
    logic [2:0]      neg;
    logic [AW-1:0]   probe;
    exp_t            e;
  } vec_t;

  logic clk = 0, rst = 0;
  logic in_valid = 0, in_ready, flip_valid = 0, flip_value = 0, out_valid, out_ready = 1, sat;
  logic [K*AW-1:0] lit_addr = '0;
  logic [2:0] lit_neg = '0, lit_val;
  logic [AW-1:0] flip_addr = '0, probe_addr = '0;
  logic [1:0] true_cnt, crit_idx;
`ifdef CLAUSE_EVAL_BREAK_EN
  logic break_hit;
`endif

  clause_evaluator_k #(.K(K), .VAR_AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .lit_addr(lit_addr), .lit_neg(lit_neg), .flip_valid(flip_valid),
    .flip_addr(flip_addr), .flip_value(flip_value), .out_valid(out_valid),
    .out_ready(out_ready), .sat(sat), .true_cnt(true_cnt), .crit_idx(crit_idx),
    .lit_val(lit_val)
`ifdef CLAUSE_EVAL_BREAK_EN
    , .probe_addr(probe_addr), .break_hit(break_hit)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, pops = 0;
  bit tab [0:(1<<AW)-1];
  exp_t q[$];
  exp_t pend;
  bit pend_set = 0, accepted = 0, saw_stall = 0;
  vec_t vecs[8];
  int vars[6] = '{1, 2, 3, 10, 20, 30};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [K*AW-1:0] a, input logic [2:0] n, input logic [AW-1:0] p);
    exp_t e;
    bit found;
    e = '0;
    found = 0;
    for (int i = 0; i < K; i++) begin
      e.lv[i] = tab[a[i*AW +: AW]] ^ n[i];
      if (e.lv[i]) begin
        e.cnt = e.cnt + 2'd1;
        if (!found) begin e.idx = 2'(i); found = 1; end
      end
    end
    e.sat = found;
    e.brk = (e.cnt == 2'd1) && (a[e.idx*AW +: AW] == p);
    return e;
  endfunction

  function automatic vec_t mkv(input int a0, a1, a2, input logic [2:0] n, input int p,
                               input logic [2:0] lv, input int c, ix, input bit s, b);
    vec_t v;
    v.addr  = {AW'(a2), AW'(a1), AW'(a0)};
    v.neg   = n;
    v.probe = AW'(p);
    v.e     = '{lv: lv, cnt: 2'(c), idx: 2'(ix), sat: s, brk: b};
    return v;
  endfunction

  // One clock: book-keep what the coming edge does (flip first = write-first), then step past it.
  task automatic cyc();
    @(negedge clk);
    if (in_valid && !in_ready) saw_stall = 1;
    accepted = in_valid && in_ready;
    if (flip_valid) tab[flip_addr] = flip_value;
    if (accepted) begin
      q.push_back(pend_set ? pend : model(lit_addr, lit_neg, probe_addr));
      pend_set = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic flip(input int a, input bit v);
    flip_valid = 1; flip_addr = AW'(a); flip_value = v;
    cyc();
    flip_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) cyc();
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic rand_clause();
    for (int i = 0; i < K; i++) lit_addr[i*AW +: AW] = AW'(vars[$urandom_range(0, 5)]);
    lit_neg    = 3'($urandom_range(0, 7));
    probe_addr = lit_addr[$urandom_range(0, K-1)*AW +: AW];
  endtask

  always @(negedge clk) begin
    exp_t f;
    if (out_valid) begin
      if (q.size() == 0) chk("unexpected_out", out_valid, 0);
      else begin
        f = q[0];
        chk("lit_val", lit_val, f.lv);
        if (out_ready) begin
          chk("sat", sat, f.sat);
          chk("true_cnt", true_cnt, f.cnt);
          chk("crit_idx", crit_idx, f.idx);
`ifdef CLAUSE_EVAL_BREAK_EN
          chk("break_hit", break_hit, f.brk);
`endif
          void'(q.pop_front());
          pops++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int sent, p0, n;
    vecs[0] = mkv( 1,  2,  3, 3'b011,  0, 3'b011, 2, 0, 1, 0);
    vecs[1] = mkv( 1,  2,  3, 3'b000,  0, 3'b000, 0, 0, 0, 0);
    vecs[2] = mkv(10, 20, 30, 3'b000,  0, 3'b011, 2, 0, 1, 0);
    vecs[3] = mkv(30,  1, 10, 3'b000, 10, 3'b100, 1, 2, 1, 1);
    vecs[4] = mkv(30, 20, 10, 3'b001,  0, 3'b111, 3, 0, 1, 0);
    vecs[5] = mkv(10, 10, 10, 3'b011, 10, 3'b100, 1, 2, 1, 1);
    vecs[6] = mkv( 1, 30,  2, 3'b010, 30, 3'b010, 1, 1, 1, 1);
    vecs[7] = mkv(20,  3,  3, 3'b001,  0, 3'b000, 0, 0, 0, 0);

    // reset
    #2 rst = 1;
    cyc(); cyc();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sat", sat, 0);
    chk("rst_true_cnt", true_cnt, 0);
    chk("rst_crit_idx", crit_idx, 0);
    chk("rst_lit_val", lit_val, 0);
    rst = 0;
    cyc();
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    flip(1, 0); flip(2, 0); flip(3, 0); flip(10, 1); flip(20, 1); flip(30, 0);

    // latency: first clause appears exactly two edges after accept
    lit_addr = vecs[0].addr; lit_neg = vecs[0].neg; probe_addr = vecs[0].probe;
    pend = vecs[0].e; pend_set = 1; in_valid = 1;
    cyc();
    in_valid = 0;
    chk("lat_accept", accepted, 1);
    chk("lat_ov_n0", out_valid, 0);
    cyc();
    chk("lat_ov_n1", out_valid, 0);
    cyc();
    chk("lat_ov_n2", out_valid, 1);
    drain();

    // vector table back to back
    for (int i = 1; i < 8; i++) begin
      lit_addr = vecs[i].addr; lit_neg = vecs[i].neg; probe_addr = vecs[i].probe;
      pend = vecs[i].e; pend_set = 1; in_valid = 1;
      cyc();
      chk("vec_accept", accepted, 1);
    end
    in_valid = 0;
    drain();

    // same-edge flip is seen, later flip is not
    flip_valid = 1; flip_addr = 11'd3; flip_value = 1;
    lit_addr = {11'd3, 11'd3, 11'd3}; lit_neg = 3'b100; probe_addr = '0;
    pend = '{lv: 3'b011, cnt: 2'd2, idx: 2'd0, sat: 1'b1, brk: 1'b0}; pend_set = 1; in_valid = 1;
    cyc();
    in_valid = 0; flip_value = 0;
    cyc();
    flip_valid = 0;
    drain();

    // stream of 8 with output stall and random flips every cycle
    p0 = pops; sent = 0; saw_stall = 0;
    rand_clause(); in_valid = 1;
    for (int c = 0; c < 60 && sent < 8; c++) begin
      out_ready  = !(c >= 3 && c <= 6);
      flip_valid = 1;
      flip_addr  = AW'(vars[$urandom_range(0, 5)]);
      flip_value = 1'($urandom_range(0, 1));
      cyc();
      if (accepted) begin
        sent++;
        if (sent < 8) rand_clause(); else in_valid = 0;
      end
    end
    in_valid = 0; flip_valid = 0; out_ready = 1;
    drain();
    chk("stream_sent", sent, 8);
    chk("stream_pops", pops - p0, 8);
    chk("stream_stall", saw_stall, 1);

    // reset with clauses in flight
    flip(1, 1); flip(10, 1); flip(30, 1);
    n = 0; in_valid = 1; rand_clause();
    for (int c = 0; c < 10 && n < 3; c++) begin
      cyc();
      if (accepted) begin n++; rand_clause(); end
    end
    in_valid = 0;
    chk("rst_pre_ov", out_valid, 1);
    rst = 1;
    #1;
    chk("rst_mid_ov", out_valid, 0);
    chk("rst_mid_rdy", in_ready, 0);
    q.delete();
    cyc(); cyc();
    rst = 0;
    chk("rst_rel_rdy0", in_ready, 0);
    cyc();
    chk("rst_rel_rdy1", in_ready, 1);
    repeat (4) cyc();
    chk("rst_no_stale", out_valid, 0);
    lit_addr = {11'd30, 11'd10, 11'd1}; lit_neg = 3'b010; probe_addr = '0;
    pend = '{lv: 3'b101, cnt: 2'd2, idx: 2'd0, sat: 1'b1, brk: 1'b0}; pend_set = 1; in_valid = 1;
    cyc();
    in_valid = 0;
    drain();

`ifdef CLAUSE_EVAL_BREAK_EN
    flip(5, 1); flip(7, 0); flip(9, 0);
    lit_addr = {11'd9, 11'd7, 11'd5}; lit_neg = 3'b000; probe_addr = 11'd5;
    pend = '{lv: 3'b001, cnt: 2'd1, idx: 2'd0, sat: 1'b1, brk: 1'b1}; pend_set = 1; in_valid = 1;
    cyc();
    probe_addr = 11'd7;
    pend = '{lv: 3'b001, cnt: 2'd1, idx: 2'd0, sat: 1'b1, brk: 1'b0}; pend_set = 1;
    cyc();
    in_valid = 0;
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
